// File: rtl/fifo_pop_stream_if.sv
// ---------------------------------------------------------------------------
// fifo_pop_stream_if
//
// Purpose: groups the handshake signals around fifo_pop_stream. This covers
// the pop side of the registered-output FIFO and the valid/ready stream that
// goes to the consumer. Signal names match the adapter's port list.
//
// Signals:
//   fifo_empty_i  FIFO empty flag (FIFO -> adapter)
//   fifo_data_i   FIFO registered read data, valid the cycle after a pop
//   fifo_pop_o    pop request (adapter -> FIFO)
//   m_valid_o     output word valid (adapter -> consumer)
//   m_data_o      output word (adapter -> consumer)
//   m_ready_i     consumer accepts the word (consumer -> adapter)
//
// Modports:
//   master  the adapter's view (drives the pop and the stream)
//   slave   the environment's view (FIFO plus consumer)
// ---------------------------------------------------------------------------
interface fifo_pop_stream_if #(
    parameter int WIDTH = 32
);
    logic             fifo_empty_i;
    logic [WIDTH-1:0] fifo_data_i;
    logic             fifo_pop_o;
    logic             m_valid_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_ready_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        input  m_ready_i,
        output fifo_pop_o,
        output m_valid_o,
        output m_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        output m_ready_i,
        input  fifo_pop_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/fifo_pop_stream.sv
// ---------------------------------------------------------------------------
// fifo_pop_stream
//
// Purpose: read-side adapter for the registered-output FIFO. The FIFO
// returns data one cycle after a pop. This block issues the pops and parks
// the returned words in a small circular buffer. It presents the words as a
// valid/ready stream that sustains one word per cycle, so consumers never
// handle pop timing or the empty flag.
//
// Parameters:
//   WIDTH      data word width in bits
//   BUF_DEPTH  output buffer entries (power of two, >= 2)
//
// Ports:
//   clk_i    clock
//   rstn_i   asynchronous active-low reset
//   flush_i  discard buffered and in-flight data (only with
//            FIFO_POP_STREAM_FLUSH_EN defined)
//   bus      fifo_pop_stream_if.master: fifo_empty_i, fifo_data_i,
//            fifo_pop_o, m_valid_o, m_data_o, m_ready_i
//
// Optional feature macro: FIFO_POP_STREAM_FLUSH_EN adds flush_i and the
// flush logic. Without it the block has no flush port.
// ---------------------------------------------------------------------------
module fifo_pop_stream #(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rstn_i,
`ifdef FIFO_POP_STREAM_FLUSH_EN
    input  logic               flush_i,
`endif
    fifo_pop_stream_if.master  bus
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] buf_r [BUF_DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic             inflight_r;

    logic             fire_w;
    logic             pop_w;
    logic [CW:0]      level_w;

    // Stream outputs come straight from registered state: the occupancy
    // counter and the buffer entry under the head pointer.
    assign bus.m_valid_o  = (count_r != '0);
    assign bus.m_data_o   = buf_r[head_r];
    assign fire_w         = bus.m_valid_o && bus.m_ready_i;
    assign bus.fifo_pop_o = pop_w;

    // Pop decision. level_w is the occupancy after this cycle's fire and
    // counts the word already in flight. The pop is allowed only if that
    // occupancy leaves room for the word it will return. The fire term lets
    // a full buffer keep popping while the consumer drains it. Gating with
    // rstn_i keeps the pop low while the block is held in reset.
    always_comb begin
        level_w = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, fire_w};
        pop_w   = rstn_i && !bus.fifo_empty_i && (level_w < {1'b0, DEPTH_C});
`ifdef FIFO_POP_STREAM_FLUSH_EN
        if (flush_i) begin
            pop_w = 1'b0;
        end
`endif
    end

    // Buffer state. A returned word is captured whenever a pop was issued
    // last cycle, and the head advances on every accepted output. A flush
    // overrides both: it empties the buffer by moving head onto tail and
    // drops the word still in flight. A word in flight when reset asserts is
    // also lost, because inflight_r is cleared.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            inflight_r <= 1'b0;
        end else begin
`ifdef FIFO_POP_STREAM_FLUSH_EN
            if (flush_i) begin
                count_r    <= '0;
                head_r     <= tail_r;
                inflight_r <= 1'b0;
            end else
`endif
            begin
                inflight_r <= pop_w;
                if (inflight_r) begin
                    buf_r[tail_r] <= bus.fifo_data_i;
                    tail_r        <= tail_r + PTR_ONE;
                end
                if (fire_w) begin
                    head_r <= head_r + PTR_ONE;
                end
                count_r <= count_r + {{PW{1'b0}}, inflight_r} - {{PW{1'b0}}, fire_w};
            end
        end
    end

    // Buffered plus in-flight words can never exceed the buffer size, and
    // the FIFO is never popped while empty.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        ({1'b0, count_r} + {{CW{1'b0}}, inflight_r}) <= {1'b0, DEPTH_C});

    a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(bus.fifo_pop_o && bus.fifo_empty_i));

endmodule

// File: tb/tb_fifo_pop_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_pop_stream
//
// Self-checking bench for fifo_pop_stream. A queue models the
// registered-output FIFO: a pop seen in one cycle puts the word on
// fifo_data_i for the next cycle. A second queue acts as the scoreboard.
// Every word loaded into the FIFO is pushed there and compared when the
// stream accepts a word.
// ---------------------------------------------------------------------------
module tb_fifo_pop_stream;

    localparam int WIDTH     = 32;
    localparam int BUF_DEPTH = 2;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
`ifdef FIFO_POP_STREAM_FLUSH_EN
    logic flush_i = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    fifo_pop_stream_if #(.WIDTH(WIDTH)) bus ();

    fifo_pop_stream #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
`ifdef FIFO_POP_STREAM_FLUSH_EN
        .flush_i (flush_i),
`endif
        .bus     (bus)
    );

    typedef struct {
        logic             ready;
        logic             expPop;
        logic             expValid;
        logic             chkData;
        logic [WIDTH-1:0] expData;
    } vec_t;

    int               checks      = 0;
    int               failures    = 0;
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] expQ[$];
    logic             smpPop;
    logic             smpValid;
    logic [WIDTH-1:0] smpData;
    int               outstanding = 0;
    int               maxOut      = 0;
    int               fires       = 0;

    // One comparison: bumps the counters and reports a mismatch.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives the consumer ready for the coming cycle.
    task automatic applyStimulus(input logic rdy);
        bus.m_ready_i = rdy;
    endtask

    // Adds a word to the FIFO model and to the expected-output scoreboard.
    task automatic loadWord(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        expQ.push_back(w);
        bus.fifo_empty_i = 1'b0;
    endtask

    // Runs one clock cycle. Outputs are sampled on the falling edge, where
    // the scoreboard and the empty-pop rule are checked. After the rising
    // edge the FIFO model returns the popped word.
    task automatic stepCycle();
        logic fireNow;
        @(negedge clk_i);
        smpPop   = bus.fifo_pop_o;
        smpValid = bus.m_valid_o;
        smpData  = bus.m_data_o;
        fireNow  = smpValid && bus.m_ready_i;
        if (bus.fifo_empty_i) begin
            checkOutput("pop_while_empty", {31'd0, smpPop}, '0);
        end
        if (fireNow) begin
            fires++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_word", smpData, 'x);
            end else begin
                checkOutput("scoreboard_word", smpData, expQ.pop_front());
            end
        end
        outstanding = outstanding + int'(smpPop) - int'(fireNow);
        if (outstanding > maxOut) maxOut = outstanding;
        @(posedge clk_i);
        #1;
        if (smpPop && fq.size() > 0) begin
            bus.fifo_data_i = fq.pop_front();
        end
        bus.fifo_empty_i = (fq.size() == 0);
    endtask

    // Holds ready high until the scoreboard is empty. It counts cycles with
    // no valid word once the first word has appeared.
    task automatic drainAll(input int budget, output int gaps);
        int n;
        bit seen;
        n    = 0;
        seen = 0;
        gaps = 0;
        applyStimulus(1'b1);
        while (expQ.size() > 0 && n < budget) begin
            stepCycle();
            n++;
            if (smpValid) seen = 1;
            else if (seen && expQ.size() > 0) gaps++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d words left required=0", expQ.size());
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   gaps;
        int   pops;
        int   n;
        int   fires0;
        bit   found;

        bus.fifo_empty_i = 1'b1;
        bus.fifo_data_i  = '0;
        bus.m_ready_i    = 1'b0;

        // Cycle table for the first burst: 0x11, 0x22, 0x33 with ready held high.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h22};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h33};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset with a non-empty FIFO: nothing may pop and the outputs stay clear.
        $display("[TB] test 1: reset and short burst");
        loadWord(32'h11);
        loadWord(32'h22);
        loadWord(32'h33);
        bus.m_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_pop",   {31'd0, bus.fifo_pop_o}, '0);
        checkOutput("reset_valid", {31'd0, bus.m_valid_o},  '0);
        checkOutput("reset_data",  bus.m_data_o,            '0);
        rstn_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].ready);
            stepCycle();
            checkOutput($sformatf("t1_pop_c%0d", i),   {31'd0, smpPop},   {31'd0, vecs[i].expPop});
            checkOutput($sformatf("t1_valid_c%0d", i), {31'd0, smpValid}, {31'd0, vecs[i].expValid});
            if (vecs[i].chkData) begin
                checkOutput($sformatf("t1_data_c%0d", i), smpData, vecs[i].expData);
            end
        end

        // Backpressure: exactly two pops, head word held, then a gapless drain.
        $display("[TB] test 2: backpressure");
        applyStimulus(1'b0);
        for (int k = 0; k < 8; k++) loadWord(32'h2000_0000 + k);
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            pops += int'(smpPop);
            if (i >= 2) begin
                checkOutput($sformatf("t2_hold_valid_c%0d", i), {31'd0, smpValid}, 32'd1);
                checkOutput($sformatf("t2_hold_data_c%0d", i),  smpData, 32'h2000_0000);
            end
        end
        checkOutput("t2_pop_count", pops, 32'd2);
        drainAll(50, gaps);
        checkOutput("t2_gaps", gaps, 32'd0);

        // Alternating ready over 100 random words.
        $display("[TB] test 3: toggling ready");
        maxOut = outstanding;
        fires0 = fires;
        for (int k = 0; k < 100; k++) loadWord($urandom);
        n = 0;
        while (expQ.size() > 0 && n < 2000) begin
            applyStimulus((n % 2) == 0);
            stepCycle();
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL t3_timeout actual=%0d words left required=0", expQ.size());
        end
        checkOutput("t3_delivered", fires - fires0, 32'd100);
        checkOutput("t3_occupancy_bound", {31'd0, maxOut <= BUF_DEPTH}, 32'd1);

        // Empty FIFO with random ready: no pops and no output.
        $display("[TB] test 4: empty FIFO");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'($urandom_range(0, 1)));
            stepCycle();
            checkOutput("t4_valid", {31'd0, smpValid}, '0);
        end

        // Reset mid-burst with one word buffered and one in flight.
        $display("[TB] test 5: reset mid-burst");
        applyStimulus(1'b0);
        for (int k = 0; k < 4; k++) loadWord(32'h5000_0000 + k);
        stepCycle();
        stepCycle();
        rstn_i = 1'b0;
        #1;
        checkOutput("t5_reset_pop",   {31'd0, bus.fifo_pop_o}, '0);
        checkOutput("t5_reset_valid", {31'd0, bus.m_valid_o},  '0);
        checkOutput("t5_reset_data",  bus.m_data_o,            '0);
        fq.delete();
        expQ.delete();
        outstanding      = 0;
        bus.fifo_empty_i = 1'b1;
        stepCycle();
        stepCycle();
        loadWord(32'hA5);
        rstn_i = 1'b1;
        applyStimulus(1'b1);
        n     = 0;
        found = 0;
        while (!found && n < 10) begin
            stepCycle();
            n++;
            if (smpValid) found = 1;
        end
        checkOutput("t5_found", {31'd0, found}, 32'd1);
        checkOutput("t5_first_word", smpData, 32'hA5);

`ifdef FIFO_POP_STREAM_FLUSH_EN
        // Flush with one word buffered and one in flight, then restart.
        $display("[TB] test 6: flush");
        applyStimulus(1'b0);
        for (int k = 0; k < 4; k++) loadWord(32'h6000_0000 + k);
        stepCycle();
        stepCycle();
        flush_i = 1'b1;
        stepCycle();
        checkOutput("t6_flush_pop", {31'd0, smpPop}, '0);
        flush_i = 1'b0;
        void'(expQ.pop_front());
        void'(expQ.pop_front());
        outstanding = 0;
        stepCycle();
        checkOutput("t6_valid_after_flush", {31'd0, smpValid}, '0);
        checkOutput("t6_first_pop", {31'd0, smpPop}, 32'd1);
        stepCycle();
        checkOutput("t6_valid_latency1", {31'd0, smpValid}, '0);
        stepCycle();
        checkOutput("t6_valid_latency2", {31'd0, smpValid}, 32'd1);
        checkOutput("t6_data", smpData, 32'h6000_0002);
        drainAll(20, gaps);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
